cisc_mem_seq: RTL and testbench
===============================

Name: cisc_mem_seq

Overview:
Parametrised memory-bus sequencer with an embedded word-addressed RAM, for the CISC core's memory side. It turns single or burst read/write requests from the core into a multi-phase bus cycle: address setup, then strobe with programmable wait states, then acknowledge. It drives the m_clk/read/write/mem_addr/mem_out debug bus used by the top-level bench. It generalises the fixed 8-bit/5-bit single-access bus to configurable data width, address width, wait states and burst length.

Parameters:
DW, 8, data word width
AW, 5, address width; RAM depth = 2**AW words
WAIT_CYC, 1, extra strobe cycles per beat (>= 0)
BLW, 3, burst-length field width; a burst is burst_len+1 beats

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
req  input  1  request strobe, sampled only in IDLE
we  input  1  1 = write, 0 = read; sampled with req
addr  input  AW  start address; sampled with req
burst_len  input  BLW  beats minus one; sampled with req
wdata  input  DW  write data; sampled in each beat's SETUP cycle
busy  output  1  high from the cycle after accepted req until return to IDLE
ack  output  1  one-cycle pulse per completed beat (DONE state)
rvalid  output  1  one-cycle pulse with ack on read beats
rdata  output  DW  read data; valid when rvalid; held until the next read beat
m_clk  output  1  bus phase clock: 0 in SETUP/DONE, 1 in STROBE
read  output  1  read strobe, high during STROBE of read beats
write  output  1  write strobe, high during STROBE of write beats
mem_addr  output  AW  current beat address (registered)
mem_out  output  DW  RAM word at mem_addr (combinational read)

Behaviour:
- Reset is asynchronous and active-high. Reset forces state IDLE; busy, ack, rvalid, m_clk, read, write = 0; rdata = 0; mem_addr = 0; beat and wait counters = 0. RAM contents are not reset.
- FSM states are IDLE, SETUP, STROBE, DONE.
- IDLE: if req=1, latch we, addr, burst_len, then go to SETUP. Otherwise stay in IDLE.
- SETUP (1 cycle): mem_addr = beat address; latch wdata; m_clk = 0. Go to STROBE.
- STROBE (WAIT_CYC+1 cycles): m_clk = 1; read or write = 1 per the latched we.
  - On the clock edge that ends the last STROBE cycle, a write commits wdata to RAM[mem_addr], and a read captures RAM[mem_addr] into rdata.
- DONE (1 cycle): ack = 1; rvalid = 1 on read beats.
  - If beats remain: address = (address+1) mod 2**AW, beat counter decrements, go to SETUP.
  - If no beats remain: go to IDLE.
- Per-beat latency is WAIT_CYC+3 cycles. The first ack is high WAIT_CYC+3 cycles after the edge that samples req. busy is high for (burst_len+1)*(WAIT_CYC+3) cycles.
- Address wrap: the beat after address 2**AW-1 is address 0. There is no error indication.
- req during busy: ignored. A new request is accepted no earlier than the IDLE cycle after the final DONE, so there is at least 1 idle cycle between transactions.
- wdata may change freely outside SETUP. The core updates wdata after each ack.
- Reset mid-operation: the FSM aborts immediately. A write whose committing edge has not yet occurred is discarded and RAM is unchanged. No ack is issued.
- All state and outputs except mem_out are registered. mem_out follows mem_addr and the RAM contents combinationally.

Test Plan:
- Bench setup: 20 ns clock, defaults (DW=8, AW=5, WAIT_CYC=1, BLW=3).
- Reset: reset=1 for 100 ns with req toggling -> busy/ack/rvalid/m_clk/read/write=0, mem_addr=0, rdata=0 throughout.
- Single write then read: write 0xA5 to addr 5 -> ack exactly 4 cycles after req edge; write high for 2 cycles with m_clk=1; then read addr 5 -> rdata=0xA5 with rvalid, mem_out=0xA5 while mem_addr=5.
- Burst with wrap: write addr=30, burst_len=3, data 0x11,0x22,0x33,0x44 -> mem_addr sequence 30,31,0,1; busy 16 cycles; 4 acks. Burst read from 30 -> rdata 0x11,0x22,0x33,0x44.
- Request while busy: assert req (read, addr 9) during a burst's STROBE -> no extra beat, busy deasserts on schedule, mem_addr never 9.
- Reset mid-write: RAM[7]=0x00; start write 0x5A to addr 7; assert reset during the first STROBE cycle -> outputs 0 immediately (asynchronous); a later read of addr 7 returns 0x00.
- WAIT_CYC=0 instance: single read -> ack 3 cycles after req; m_clk/read high for exactly 1 cycle.

Source files
------------

// File: rtl/cisc_mem_seq.sv
// rtl/cisc_mem_seq.sv - memory-bus sequencer with embedded word RAM
// Single/burst accesses run SETUP -> STROBE (WAIT_CYC+1) -> DONE per beat.
module cisc_mem_seq #(
  parameter int DW       = 8,
  parameter int AW       = 5,
  parameter int WAIT_CYC = 1,
  parameter int BLW      = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req,
  input  logic          we,
  input  logic [AW-1:0]  addr,
  input  logic [BLW-1:0] burst_len,
  input  logic [DW-1:0]  wdata,
  output logic          busy,
  output logic          ack,
  output logic          rvalid,
  output logic [DW-1:0]  rdata,
  output logic          m_clk,
  output logic          read,
  output logic          write,
  output logic [AW-1:0]  mem_addr,
  output logic [DW-1:0]  mem_out
);

  localparam int WCW = (WAIT_CYC > 0) ? $clog2(WAIT_CYC + 1) : 1;
  localparam logic [WCW-1:0] WAIT_LOAD = WCW'(WAIT_CYC);

  typedef enum logic [1:0] {IDLE, SETUP, STROBE, DONE} state_t;

  state_t         state, state_n;
  logic           we_q, we_n;
  logic [AW-1:0]  addr_n;
  logic [BLW-1:0] beats, beats_n;
  logic [WCW-1:0] wait_cnt, wait_n;
  logic [DW-1:0]  wdata_q;
  logic           commit;

  logic [DW-1:0]  ram [2**AW];

  always_comb begin
    state_n = state;
    we_n    = we_q;
    addr_n  = mem_addr;
    beats_n = beats;
    wait_n  = wait_cnt;
    commit  = 1'b0;
    case (state)
      IDLE: begin
        if (req) begin
          state_n = SETUP;
          we_n    = we;
          addr_n  = addr;
          beats_n = burst_len;
        end
      end
      SETUP: begin
        state_n = STROBE;
        wait_n  = WAIT_LOAD;
      end
      STROBE: begin
        // The edge leaving the last strobe cycle is the one that moves data.
        if (wait_cnt == '0) begin
          state_n = DONE;
          commit  = 1'b1;
        end else begin
          wait_n = wait_cnt - WCW'(1);
        end
      end
      DONE: begin
        if (beats != '0) begin
          state_n = SETUP;
          beats_n = beats - BLW'(1);
          addr_n  = mem_addr + AW'(1);
        end else begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with the state they describe.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      we_q     <= 1'b0;
      mem_addr <= '0;
      beats    <= '0;
      wait_cnt <= '0;
      wdata_q  <= '0;
      rdata    <= '0;
      busy     <= 1'b0;
      ack      <= 1'b0;
      rvalid   <= 1'b0;
      m_clk    <= 1'b0;
      read     <= 1'b0;
      write    <= 1'b0;
    end else begin
      state    <= state_n;
      we_q     <= we_n;
      mem_addr <= addr_n;
      beats    <= beats_n;
      wait_cnt <= wait_n;
      busy     <= (state_n != IDLE);
      ack      <= (state_n == DONE);
      rvalid   <= (state_n == DONE) && !we_n;
      m_clk    <= (state_n == STROBE);
      read     <= (state_n == STROBE) && !we_n;
      write    <= (state_n == STROBE) && we_n;
      if (state == SETUP) wdata_q <= wdata;
      if (commit && !we_q) rdata <= ram[mem_addr];
    end
  end

  // RAM is not reset; an aborted write never reaches commit because reset forces IDLE.
  always_ff @(posedge clk) begin
    if (commit && we_q) ram[mem_addr] <= wdata_q;
  end

  assign mem_out = ram[mem_addr];

endmodule

// File: tb/tb_cisc_mem_seq.sv
// tb/tb_cisc_mem_seq.sv - self-checking bench for cisc_mem_seq
// Two instances (WAIT_CYC=1 and WAIT_CYC=0) checked cycle by cycle against a RAM/latency model.
module tb_cisc_mem_seq;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       req = 1'b0;
  logic       we = 1'b0;
  logic [4:0] addr = '0;
  logic [2:0] burst_len = '0;
  logic [7:0] wdata = '0;
  logic       sel = 1'b0;

  logic       req1, req0;
  logic       busy1, ack1, rvalid1, m_clk1, read1, write1;
  logic [7:0] rdata1, mem_out1;
  logic [4:0] mem_addr1;
  logic       busy0, ack0, rvalid0, m_clk0, read0, write0;
  logic [7:0] rdata0, mem_out0;
  logic [4:0] mem_addr0;

  assign req1 = req & ~sel;
  assign req0 = req & sel;

  cisc_mem_seq #(.DW(8), .AW(5), .WAIT_CYC(1), .BLW(3)) dut (
    .clk(clk), .reset(reset), .req(req1), .we(we), .addr(addr), .burst_len(burst_len),
    .wdata(wdata), .busy(busy1), .ack(ack1), .rvalid(rvalid1), .rdata(rdata1),
    .m_clk(m_clk1), .read(read1), .write(write1), .mem_addr(mem_addr1), .mem_out(mem_out1));

  cisc_mem_seq #(.DW(8), .AW(5), .WAIT_CYC(0), .BLW(3)) dut0 (
    .clk(clk), .reset(reset), .req(req0), .we(we), .addr(addr), .burst_len(burst_len),
    .wdata(wdata), .busy(busy0), .ack(ack0), .rvalid(rvalid0), .rdata(rdata0),
    .m_clk(m_clk0), .read(read0), .write(write0), .mem_addr(mem_addr0), .mem_out(mem_out0));

  always #10 clk = ~clk;

  logic       o_busy, o_ack, o_rvalid, o_m_clk, o_read, o_write;
  logic [7:0] o_rdata, o_mem_out;
  logic [4:0] o_mem_addr;
  assign o_busy     = sel ? busy0 : busy1;
  assign o_ack      = sel ? ack0 : ack1;
  assign o_rvalid   = sel ? rvalid0 : rvalid1;
  assign o_m_clk    = sel ? m_clk0 : m_clk1;
  assign o_read     = sel ? read0 : read1;
  assign o_write    = sel ? write0 : write1;
  assign o_rdata    = sel ? rdata0 : rdata1;
  assign o_mem_out  = sel ? mem_out0 : mem_out1;
  assign o_mem_addr = sel ? mem_addr0 : mem_addr1;

  int         compared = 0;
  int         mismatched = 0;
  logic [7:0] model [2][32];
  logic [7:0] last_rd [2];
  logic [7:0] txn_data [8];

  task automatic chk1(input string tag, input logic obs, input logic exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chkv(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_rst(input string tag);
    chkv({tag, "_ctl1"}, 32'({busy1, ack1, rvalid1, m_clk1, read1, write1}), 32'd0);
    chkv({tag, "_addr1"}, 32'(mem_addr1), 32'd0);
    chkv({tag, "_rdata1"}, 32'(rdata1), 32'd0);
    chkv({tag, "_ctl0"}, 32'({busy0, ack0, rvalid0, m_clk0, read0, write0}), 32'd0);
    chkv({tag, "_addr0"}, 32'(mem_addr0), 32'd0);
    chkv({tag, "_rdata0"}, 32'(rdata0), 32'd0);
  endtask

  // Beat b occupies cycles b*P+1 .. b*P+P after the req edge: SETUP, strobes, DONE.
  task automatic run_txn(input logic s, input logic w, input logic [4:0] a,
                         input logic [2:0] bl, input int intr);
    int p, n_tot, di, b, ph, first_ack;
    logic [4:0] ea;
    logic ex_strobe, ex_done;
    p = s ? 3 : 4;
    n_tot = (int'(bl) + 1) * p;
    di = s ? 1 : 0;
    first_ack = -1;
    @(negedge clk);
    sel = s; req = 1'b1; we = w; addr = a; burst_len = bl; wdata = 8'($urandom);
    @(posedge clk);
    for (int n = 1; n <= n_tot; n++) begin
      @(negedge clk);
      b = (n - 1) / p;
      ph = (n - 1) % p;
      ea = a + 5'(b);
      ex_strobe = (ph > 0) && (ph < p - 1);
      ex_done = (ph == p - 1);
      req = (n == intr);
      if (n == intr) begin
        we = 1'b0; addr = 5'd9; burst_len = 3'($urandom);
      end
      wdata = (ph == 0) ? txn_data[b] : 8'($urandom);
      if (ex_done) begin
        if (w) model[di][ea] = txn_data[b];
        else   last_rd[di] = model[di][ea];
      end
      if (o_ack && first_ack < 0) first_ack = n;
      chk1("busy", o_busy, 1'b1);
      chk1("ack", o_ack, ex_done);
      chk1("rvalid", o_rvalid, ex_done && !w);
      chk1("m_clk", o_m_clk, ex_strobe);
      chk1("read", o_read, ex_strobe && !w);
      chk1("write", o_write, ex_strobe && w);
      chkv("mem_addr", 32'(o_mem_addr), 32'(ea));
      chkv("mem_out", 32'(o_mem_out), 32'(model[di][ea]));
      chkv("rdata", 32'(o_rdata), 32'(last_rd[di]));
    end
    @(negedge clk);
    req = 1'b0;
    chk1("idle_busy", o_busy, 1'b0);
    chkv("idle_ctl", 32'({o_ack, o_rvalid, o_m_clk, o_read, o_write}), 32'd0);
    chkv("idle_rdata", 32'(o_rdata), 32'(last_rd[di]));
    chkv("first_ack", 32'(first_ack), 32'(p));
  endtask

  initial begin
    logic [4:0] ra;
    logic [2:0] rbl;
    logic       rw;
    int         intr;
    last_rd[0] = 8'h00;
    last_rd[1] = 8'h00;

    // Reset held for 100 ns with req toggling.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      req = ~req; we = 1'($urandom); addr = 5'($urandom);
      check_rst("reset");
    end
    req = 1'b0;
    reset = 1'b0;

    // Fill the whole RAM with random data in four 8-beat bursts.
    for (int k = 0; k < 4; k++) begin
      for (int j = 0; j < 8; j++) txn_data[j] = 8'($urandom);
      run_txn(1'b0, 1'b1, 5'(k * 8), 3'd7, 0);
    end

    // Single write then read.
    txn_data[0] = 8'hA5;
    run_txn(1'b0, 1'b1, 5'd5, 3'd0, 0);
    run_txn(1'b0, 1'b0, 5'd5, 3'd0, 0);
    chkv("read_a5", 32'(rdata1), 32'h0000_00A5);

    // Burst across the address wrap, then read it back with an intruding req.
    txn_data[0] = 8'h11; txn_data[1] = 8'h22; txn_data[2] = 8'h33; txn_data[3] = 8'h44;
    run_txn(1'b0, 1'b1, 5'd30, 3'd3, 0);
    run_txn(1'b0, 1'b0, 5'd30, 3'd3, 2);
    chkv("wrap_last", 32'(rdata1), 32'h0000_0044);

    // Random transactions, some with ignored requests during busy.
    for (int t = 0; t < 10; t++) begin
      rw = 1'($urandom);
      ra = 5'($urandom);
      rbl = 3'($urandom);
      intr = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, (int'(rbl) + 1) * 4)) : 0;
      for (int j = 0; j < 8; j++) txn_data[j] = 8'($urandom);
      run_txn(1'b0, rw, ra, rbl, intr);
    end

    // Reset during the first strobe of a write must discard it.
    txn_data[0] = 8'h00;
    run_txn(1'b0, 1'b1, 5'd7, 3'd0, 0);
    @(negedge clk);
    sel = 1'b0; req = 1'b1; we = 1'b1; addr = 5'd7; burst_len = 3'd0;
    @(posedge clk);
    @(negedge clk);
    req = 1'b0; wdata = 8'h5A;
    @(posedge clk);
    #2;
    chk1("pre_rst_write", write1, 1'b1);
    reset = 1'b1;
    #1;
    check_rst("async_rst");
    @(negedge clk);
    check_rst("held_rst");
    reset = 1'b0;
    last_rd[0] = 8'h00;
    last_rd[1] = 8'h00;
    run_txn(1'b0, 1'b0, 5'd7, 3'd0, 0);
    chkv("aborted_write", 32'(rdata1), 32'd0);

    // Zero-wait instance: single write/read and a short burst.
    ra = 5'($urandom);
    txn_data[0] = 8'($urandom);
    run_txn(1'b1, 1'b1, ra, 3'd0, 0);
    run_txn(1'b1, 1'b0, ra, 3'd0, 0);
    ra = 5'($urandom);
    for (int j = 0; j < 8; j++) txn_data[j] = 8'($urandom);
    run_txn(1'b1, 1'b1, ra, 3'd2, 0);
    run_txn(1'b1, 1'b0, ra, 3'd2, 4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
